// File: rtl/smj_pkg.sv
// Shared tile/class definitions and modulo helpers for the SMJ hand dealer.
package smj_pkg;

    localparam int unsigned TILE_W = 6;
    localparam int unsigned VAL_W  = 4;
    localparam int unsigned SEED_W = 12;
    localparam int unsigned IDX_W  = 3;
    localparam int unsigned HAND_N = 5;

    localparam logic [1:0] HONOR      = 2'b00;
    localparam logic [1:0] NOWINNING  = 2'b00;
    localparam logic [1:0] IMPOSSIBLE = 2'b01;
    localparam logic [1:0] PAIR_SEQ   = 2'b10;
    localparam logic [1:0] PAIR_TRI   = 2'b11;

    localparam logic [VAL_W-1:0] HONOR_LIMIT = 4'd7;
    localparam logic [VAL_W-1:0] NUM_LIMIT   = 4'd9;

    typedef struct packed {
        logic [1:0]       suit;
        logic [VAL_W-1:0] value;
    } tile_t;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        BUILD = 2'b01,
        SEND  = 2'b10
    } state_t;

    // Inputs never exceed 15 and limits are >= 7, so two subtractions cover every case.
    function automatic logic [VAL_W-1:0] mod_lim(input logic [VAL_W-1:0] v,
                                                 input logic [VAL_W-1:0] lim);
        logic [VAL_W-1:0] r;
        r = v;
        if (r >= lim) r = r - lim;
        if (r >= lim) r = r - lim;
        return r;
    endfunction

    function automatic logic [VAL_W-1:0] limit_of(input logic [1:0] suit);
        return (suit == HONOR) ? HONOR_LIMIT : NUM_LIMIT;
    endfunction

endpackage

// File: rtl/smj_legalize.sv
// Folds an arbitrary 6-bit tile code onto a legal tile of the same suit.
module smj_legalize
    import smj_pkg::*;
(
    input  logic [TILE_W-1:0] tile_i,
    output logic [TILE_W-1:0] tile_c
);

    tile_t raw;
    tile_t legal;

    always_comb begin
        raw         = tile_t'(tile_i);
        legal.suit  = raw.suit;
        legal.value = mod_lim(raw.value, limit_of(raw.suit));
        tile_c      = TILE_W'(legal);
    end

endmodule

// File: rtl/smj_dealer.sv
// Captures a request, builds a five-tile hand of the requested class in one
// cycle, then streams it out under valid/ready handshake.
module smj_dealer
    import smj_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [1:0]        in_type,
    input  logic [SEED_W-1:0] in_seed,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [TILE_W-1:0] out_tile,
    output logic              out_last,
    output logic              busy
);

    state_t              state_q, state_d;
    logic [1:0]          type_q, type_d;
    logic [SEED_W-1:0]   seed_q, seed_d;
    tile_t               bank_q [HAND_N];
    tile_t               bank_d [HAND_N];
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic                out_valid_q, out_valid_d;
    tile_t               out_tile_q, out_tile_d;
    logic                out_last_q, out_last_d;
    logic                busy_q, busy_d;
    logic                load;

    logic [TILE_W-1:0]   p_raw, m_raw;
    tile_t               p_t, m_t, t_t, s_t;
    logic [VAL_W-1:0]    honor_v;
    tile_t               hand_c [HAND_N];

    smj_legalize u_leg_p (.tile_i(seed_q[5:0]),  .tile_c(p_raw));
    smj_legalize u_leg_m (.tile_i(seed_q[11:6]), .tile_c(m_raw));

    // Hand construction from the captured seed and class.
    always_comb begin
        p_t = tile_t'(p_raw);
        m_t = tile_t'(m_raw);
        t_t = m_t;
        if (m_t == p_t) t_t.value = mod_lim(m_t.value + 4'd1, limit_of(m_t.suit));
        s_t.suit  = (seed_q[11:10] == HONOR) ? 2'b01 : seed_q[11:10];
        s_t.value = mod_lim(seed_q[9:6], HONOR_LIMIT);
        honor_v   = mod_lim({1'b0, seed_q[2:0]}, HONOR_LIMIT);
        for (int k = 0; k < HAND_N; k++) hand_c[k] = p_t;
        case (type_q)
            PAIR_TRI: begin
                hand_c[2] = t_t;
                hand_c[3] = t_t;
                hand_c[4] = t_t;
            end
            PAIR_SEQ: begin
                hand_c[2] = s_t;
                hand_c[3] = tile_t'({s_t.suit, s_t.value + 4'd1});
                hand_c[4] = tile_t'({s_t.suit, s_t.value + 4'd2});
            end
            NOWINNING: begin
                for (int k = 0; k < HAND_N; k++) begin
                    hand_c[k].suit  = HONOR;
                    hand_c[k].value = mod_lim(honor_v + VAL_W'(k), HONOR_LIMIT);
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        type_d      = type_q;
        seed_d      = seed_q;
        bank_d      = bank_q;
        idx_d       = idx_q;
        out_valid_d = out_valid_q;
        out_tile_d  = out_tile_q;
        out_last_d  = out_last_q;
        busy_d      = busy_q;
        load        = 1'b0;
        case (state_q)
            IDLE: begin
                if (in_valid && !busy_q) begin
                    type_d  = in_type;
                    seed_d  = in_seed;
                    busy_d  = 1'b1;
                    state_d = BUILD;
                end
            end
            BUILD: begin
                bank_d  = hand_c;
                idx_d   = '0;
                state_d = SEND;
            end
            SEND: begin
                if (!out_valid_q) begin
                    load = 1'b1;
                end else if (out_ready) begin
                    if (out_last_q) begin
                        out_valid_d = 1'b0;
                        out_last_d  = 1'b0;
                        busy_d      = 1'b0;
                        state_d     = IDLE;
                    end else begin
                        load = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        // Present the next bank entry on the output register.
        if (load) begin
            out_valid_d = 1'b1;
            out_tile_d  = bank_q[idx_q];
            out_last_d  = (idx_q == IDX_W'(HAND_N - 1));
            idx_d       = idx_q + IDX_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            type_q      <= '0;
            seed_q      <= '0;
            for (int k = 0; k < HAND_N; k++) bank_q[k] <= '0;
            idx_q       <= '0;
            out_valid_q <= 1'b0;
            out_tile_q  <= '0;
            out_last_q  <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            type_q      <= type_d;
            seed_q      <= seed_d;
            bank_q      <= bank_d;
            idx_q       <= idx_d;
            out_valid_q <= out_valid_d;
            out_tile_q  <= out_tile_d;
            out_last_q  <= out_last_d;
            busy_q      <= busy_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_tile  = TILE_W'(out_tile_q);
    assign out_last  = out_last_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_smj_dealer.sv
// Directed bench for smj_dealer: fixed hands, backpressure, reset abort,
// back-to-back requests and an independent hand classifier.
module tb_smj_dealer;

    logic        clk       = 1'b0;
    logic        rst_n     = 1'b0;
    logic        in_valid  = 1'b0;
    logic [1:0]  in_type   = 2'b00;
    logic [11:0] in_seed   = 12'h000;
    logic        out_ready = 1'b0;
    logic        out_valid;
    logic [5:0]  out_tile;
    logic        out_last;
    logic        busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    smj_dealer dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_type  (in_type),
        .in_seed  (in_seed),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_tile (out_tile),
        .out_last (out_last),
        .busy     (busy)
    );

    function automatic bit seq3(input logic [5:0] x, input logic [5:0] y, input logic [5:0] z);
        logic [3:0] mn;
        if (x[5:4] != y[5:4] || x[5:4] != z[5:4] || x[5:4] == 2'b00) return 1'b0;
        if (x == y || y == z || x == z) return 1'b0;
        mn = x[3:0];
        if (y[3:0] < mn) mn = y[3:0];
        if (z[3:0] < mn) mn = z[3:0];
        return (x[3:0] - mn <= 4'd2) && (y[3:0] - mn <= 4'd2) && (z[3:0] - mn <= 4'd2);
    endfunction

    // Independent SMJ classifier over a packed hand (tile 0 in the top bits).
    function automatic logic [1:0] classify(input logic [29:0] hv);
        logic [5:0] a [5];
        int         cnt [5];
        logic       has2, has3;
        logic [5:0] r0, r1, r2;
        for (int k = 0; k < 5; k++) a[k] = hv[(4-k)*6 +: 6];
        has2 = 1'b0;
        has3 = 1'b0;
        for (int i = 0; i < 5; i++) begin
            cnt[i] = 0;
            for (int j = 0; j < 5; j++) if (a[j] == a[i]) cnt[i]++;
        end
        if (cnt[0] == 5) return 2'b01;
        for (int i = 0; i < 5; i++) begin
            if (cnt[i] == 3) has3 = 1'b1;
            if (cnt[i] == 2) has2 = 1'b1;
        end
        if (has2 && has3) return 2'b11;
        for (int i = 0; i < 5; i++) begin
            for (int j = i + 1; j < 5; j++) begin
                if (a[i] == a[j] && cnt[i] == 2) begin
                    r0 = '0; r1 = '0; r2 = '0;
                    for (int m = 0; m < 5; m++) begin
                        if (m != i && m != j) begin
                            r2 = r1; r1 = r0; r0 = a[m];
                        end
                    end
                    if (seq3(r0, r1, r2)) return 2'b10;
                end
            end
        end
        return 2'b00;
    endfunction

    // Issue one request from a negedge and collect the hand with out_ready held high.
    task automatic run_hand(input string name, input logic [1:0] t, input logic [11:0] s,
                            input logic [29:0] exp);
        logic [29:0] got;
        logic [5:0]  e;
        int          n;
        got = '0;
        n   = 0;
        while (busy && n < 20) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL %s idle_wait: busy=%b required 0", name, busy);
        end
        in_valid = 1'b1; in_type = t; in_seed = s; out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        checks++;
        if (busy !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL %s accept: busy=%b valid=%b required busy=1 valid=0", name, busy, out_valid);
        end
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL %s latency: valid=%b required 0 one cycle after accept", name, out_valid);
        end
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            e = exp[(4-k)*6 +: 6];
            checks++;
            if (out_valid !== 1'b1 || out_tile !== e || out_last !== (k == 4)) begin
                errors++;
                $display("FAIL %s tile%0d: valid=%b tile=0x%02h last=%b required valid=1 tile=0x%02h last=%b",
                         name, k, out_valid, out_tile, out_last, e, (k == 4));
            end
            got[(4-k)*6 +: 6] = out_tile;
        end
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL %s done: valid=%b busy=%b required 0 0", name, out_valid, busy);
        end
        checks++;
        if (classify(got) !== t) begin
            errors++;
            $display("FAIL %s classify: class=%b required %b", name, classify(got), t);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        in_valid = 1'b1; in_type = 2'b11; in_seed = 12'h953;
        repeat (3) @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || out_tile !== 6'h00 || busy !== 1'b0 || out_last !== 1'b0) begin
            errors++;
            $display("FAIL reset_hold: valid=%b tile=0x%02h busy=%b last=%b required 0 0x00 0 0",
                     out_valid, out_tile, busy, out_last);
        end
        in_valid = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: valid=%b busy=%b required 0 0", out_valid, busy);
        end
    endtask

    task automatic test_pair_triplet();
        run_hand("tri_953", 2'b11, 12'h953, {6'h13, 6'h13, 6'h25, 6'h25, 6'h25});
        run_hand("tri_4d3", 2'b11, 12'h4D3, {6'h13, 6'h13, 6'h14, 6'h14, 6'h14});
    endtask

    task automatic test_pair_seq();
        run_hand("seq_27f", 2'b10, 12'h27F, {6'h36, 6'h36, 6'h12, 6'h13, 6'h14});
    endtask

    task automatic test_nowin_impossible();
        run_hand("nowin_005", 2'b00, 12'h005, {6'h05, 6'h06, 6'h00, 6'h01, 6'h02});
        run_hand("imp_013", 2'b01, 12'h013, {6'h13, 6'h13, 6'h13, 6'h13, 6'h13});
    endtask

    task automatic test_back_to_back();
        run_hand("b2b_a", 2'b10, 12'h27F, {6'h36, 6'h36, 6'h12, 6'h13, 6'h14});
        run_hand("b2b_b", 2'b11, 12'h953, {6'h13, 6'h13, 6'h25, 6'h25, 6'h25});
    endtask

    task automatic test_backpressure();
        logic [29:0] exp;
        logic [29:0] got;
        logic [5:0]  e;
        exp = {6'h13, 6'h13, 6'h25, 6'h25, 6'h25};
        got = '0;
        in_valid = 1'b1; in_type = 2'b11; in_seed = 12'h953; out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            if (k == 1) @(negedge clk);
            checks++;
            if (out_valid !== 1'b1 || out_tile !== 6'h13 || out_last !== 1'b0) begin
                errors++;
                $display("FAIL bp_tile%0d: valid=%b tile=0x%02h last=%b required 1 0x13 0",
                         k, out_valid, out_tile, out_last);
            end
            got[(4-k)*6 +: 6] = out_tile;
        end
        out_ready = 1'b0;
        in_valid = 1'b1; in_type = 2'b01; in_seed = 12'h005;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            in_valid = 1'b0;
            checks++;
            if (out_valid !== 1'b1 || out_tile !== 6'h13 || out_last !== 1'b0 || busy !== 1'b1) begin
                errors++;
                $display("FAIL bp_hold%0d: valid=%b tile=0x%02h last=%b busy=%b required 1 0x13 0 1",
                         c, out_valid, out_tile, out_last, busy);
            end
        end
        out_ready = 1'b1;
        for (int k = 2; k < 5; k++) begin
            @(negedge clk);
            e = exp[(4-k)*6 +: 6];
            checks++;
            if (out_valid !== 1'b1 || out_tile !== e || out_last !== (k == 4)) begin
                errors++;
                $display("FAIL bp_tile%0d: valid=%b tile=0x%02h last=%b required 1 0x%02h %b",
                         k, out_valid, out_tile, out_last, e, (k == 4));
            end
            got[(4-k)*6 +: 6] = out_tile;
        end
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL bp_no_extra%0d: valid=%b busy=%b required 0 0", c, out_valid, busy);
            end
        end
        checks++;
        if (classify(got) !== 2'b11) begin
            errors++;
            $display("FAIL bp_classify: class=%b required 11", classify(got));
        end
    endtask

    task automatic test_reset_mid();
        in_valid = 1'b1; in_type = 2'b11; in_seed = 12'h953; out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (5) @(negedge clk);
        checks++;
        if (out_valid !== 1'b1 || out_tile !== 6'h25) begin
            errors++;
            $display("FAIL mid_tile2: valid=%b tile=0x%02h required 1 0x25", out_valid, out_tile);
        end
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_tile !== 6'h00 || busy !== 1'b0 || out_last !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset: valid=%b tile=0x%02h busy=%b last=%b required 0 0x00 0 0",
                     out_valid, out_tile, busy, out_last);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL mid_resume: valid=%b busy=%b required 0 0", out_valid, busy);
        end
        run_hand("post_reset", 2'b11, 12'h953, {6'h13, 6'h13, 6'h25, 6'h25, 6'h25});
    endtask

    initial begin
        test_reset();
        test_pair_triplet();
        test_pair_seq();
        test_nowin_impossible();
        test_back_to_back();
        test_backpressure();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded 200000 time units");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/smj_dealer.md
SMJ_DEALER -- requirements
Module: smj_dealer

Interface
REQ-001 SHALL have ports: clk  input  1  rising-edge clock; rst_n  input  1  reset, asynchronous, active-low.
REQ-002 SHALL have ports: in_valid  input  1  request strobe; in_type  input  2  requested class (00 no-win, 01 impossible, 10 pair+sequence, 11 pair+triplet); in_seed  input  12  hand seed.
REQ-003 SHALL have ports: out_valid  output  1  tile valid; out_ready  input  1  sink accepts tile; out_tile  output  6  tile {suit[5:4], value[3:0]}; out_last  output  1  fifth tile; busy  output  1  request in progress.
REQ-004 Tile encoding SHALL be: suit 00 honor with values 0..6; suits 01/10/11 numbered with values 0..8.

Function
REQ-005 SHALL accept a request only when in_valid=1 and busy=0; in_type and in_seed are captured on that edge, and busy rises the same edge.
REQ-006 in_valid while busy=1 SHALL be ignored.
REQ-007 FSM states SHALL be IDLE -> BUILD (1 cycle, computes all five tiles into a register bank) -> SEND (tiles 0..4) -> IDLE.
REQ-008 First out_valid SHALL appear 2 cycles after the accepting edge.
REQ-009 A tile SHALL transfer on a cycle with out_valid=1 and out_ready=1; with out_ready=0, out_tile/out_last SHALL hold stable.
REQ-010 out_last SHALL be 1 only with tile 4; after tile 4 transfers, out_valid=0 and busy=0 on the next cycle, and a new request is accepted on that cycle.
REQ-011 legalize(t): suit unchanged; honor value = value mod 7; numbered value = value mod 9.
REQ-012 P = legalize(seed[5:0]); M = legalize(seed[11:6]).
REQ-013 Type 11 SHALL emit P,P,T,T,T with T = M; if M == P, T value = (M value + 1) mod limit, same suit.
REQ-014 Type 10 SHALL emit P,P,S,S+1,S+2, where S has suit seed[11:10], forced to 01 if 00, and value = seed[9:6] mod 7.
REQ-015 Type 01 SHALL emit P five times.
REQ-016 Type 00 SHALL emit honors with values (v+k) mod 7 for k=0..4, where v = seed[2:0] mod 7.
REQ-017 Tiles SHALL be emitted in the order listed; the set SHALL satisfy the SMJ classifier for the requested class.
REQ-018 All arithmetic SHALL be 4-bit unsigned with explicit modulo and no wrap beyond the limit.

Reset
REQ-019 While rst_n=0, SHALL force state IDLE, out_valid=0, out_tile=6'h00, out_last=0, busy=0, and clear the tile bank.
REQ-020 Reset mid-SEND SHALL abort the hand with no partial resumption; the first post-reset request behaves as from power-up.

Structure
REQ-021 Shared package smj_pkg SHALL hold suit/class constants (HONOR, NOWINNING, IMPOSSIBLE, PAIR_SEQ, PAIR_TRI), the tile typedef, and the limit constants 7/9.
REQ-022 SHALL instantiate one combinational sub-module smj_legalize (6-bit tile in -> legal 6-bit tile out), used for P and M.
REQ-023 A 3-bit tile index counter SHALL select from the five-entry tile bank.

Verification
REQ-024 Reset: hold rst_n=0 -> out_valid=0, out_tile=0x00, busy=0.
REQ-025 type=11, seed=0x953, out_ready=1 -> tiles 0x13,0x13,0x25,0x25,0x25 on consecutive cycles from cycle+2; out_last on 0x25 #3.
REQ-026 type=10, seed=0x27F -> 0x36,0x36,0x12,0x13,0x14; type=11, seed=0x4D3 -> 0x13,0x13,0x14,0x14,0x14.
REQ-027 type=00, seed=0x005 -> 0x05,0x06,0x00,0x01,0x02; type=01, seed=0x013 -> 0x13 x5.
REQ-028 out_ready=0 for 3 cycles at tile 1, plus in_valid pulse while busy -> tile 1 held stable, no extra hand, order unchanged.
REQ-029 rst_n pulse after tile 2 -> out_valid=0 immediately; a following type=11, seed=0x953 request yields the full REQ-025 sequence; every emitted hand is checked against the SMJ classifier.
